// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with freeze (stall), flush (bubble) and
// write-back snoop so held operands track the register file.
//
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   freeze, flush     hold / kill contents (flush has priority)
//   id_*              decode-stage operands, addresses and controls
//   wb_en/dest/value  write-back port, snooped while frozen
//   ex_*              registered copies of id_*, plus ex_valid
//   stall_cnt,        saturating event counters, present only when
//   flush_cnt         ID_EX_STALL_CNT_EN is defined
module id_ex_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_val_rn,
    input  logic [DATA_W-1:0]     id_val_rm,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [3:0]            id_exe_cmd,
    input  logic                  id_mem_r_en,
    input  logic                  id_mem_w_en,
    input  logic                  id_wb_en,
    input  logic                  id_b,
    input  logic                  id_s,
    input  logic                  id_imm,
    input  logic [11:0]           id_shift_operand,
    input  logic [23:0]           id_signed_imm_24,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0]     wb_value,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_val_rn,
    output logic [DATA_W-1:0]     ex_val_rm,
    output logic [REG_ADDR_W-1:0] ex_src1,
    output logic [REG_ADDR_W-1:0] ex_src2,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic [3:0]            ex_exe_cmd,
    output logic                  ex_mem_r_en,
    output logic                  ex_mem_w_en,
    output logic                  ex_wb_en,
    output logic                  ex_b,
    output logic                  ex_s,
    output logic                  ex_imm,
    output logic [11:0]           ex_shift_operand,
`ifdef ID_EX_STALL_CNT_EN
    output logic [23:0]           ex_signed_imm_24,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`else
    output logic [23:0]           ex_signed_imm_24
`endif
);

    // Highest address is the PC, never written through the file.
    localparam logic [REG_ADDR_W-1:0] PC_IDX = '1;

    logic wb_ok;
    logic snoop_rn;
    logic snoop_rm;

    assign wb_ok    = wb_en && ex_valid && (wb_dest != PC_IDX);
    assign snoop_rn = wb_ok && (wb_dest == ex_src1);
    assign snoop_rm = wb_ok && (wb_dest == ex_src2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid         <= 1'b0;
            ex_pc            <= '0;
            ex_val_rn        <= '0;
            ex_val_rm        <= '0;
            ex_src1          <= '0;
            ex_src2          <= '0;
            ex_dest          <= '0;
            ex_exe_cmd       <= '0;
            ex_mem_r_en      <= 1'b0;
            ex_mem_w_en      <= 1'b0;
            ex_wb_en         <= 1'b0;
            ex_b             <= 1'b0;
            ex_s             <= 1'b0;
            ex_imm           <= 1'b0;
            ex_shift_operand <= '0;
            ex_signed_imm_24 <= '0;
        end else if (flush) begin
            ex_valid         <= 1'b0;
            ex_pc            <= '0;
            ex_val_rn        <= '0;
            ex_val_rm        <= '0;
            ex_src1          <= '0;
            ex_src2          <= '0;
            ex_dest          <= '0;
            ex_exe_cmd       <= '0;
            ex_mem_r_en      <= 1'b0;
            ex_mem_w_en      <= 1'b0;
            ex_wb_en         <= 1'b0;
            ex_b             <= 1'b0;
            ex_s             <= 1'b0;
            ex_imm           <= 1'b0;
            ex_shift_operand <= '0;
            ex_signed_imm_24 <= '0;
        end else if (freeze) begin
            // Held operands follow write-backs that land while stalled.
            if (snoop_rn) ex_val_rn <= wb_value;
            if (snoop_rm) ex_val_rm <= wb_value;
        end else begin
            // Register file writes on the falling edge, so id_val_*
            // already include this cycle's write-back.
            ex_valid         <= id_valid;
            ex_pc            <= id_pc;
            ex_val_rn        <= id_val_rn;
            ex_val_rm        <= id_val_rm;
            ex_src1          <= id_src1;
            ex_src2          <= id_src2;
            ex_dest          <= id_dest;
            ex_exe_cmd       <= id_exe_cmd;
            ex_mem_r_en      <= id_mem_r_en;
            ex_mem_w_en      <= id_mem_w_en;
            ex_wb_en         <= id_wb_en;
            ex_b             <= id_b;
            ex_s             <= id_s;
            ex_imm           <= id_imm;
            ex_shift_operand <= id_shift_operand;
            ex_signed_imm_24 <= id_signed_imm_24;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (freeze && !flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: reset, load, freeze hold,
// write-back snoop, flush priority and optional counters.
module tb_id_ex_pipe_reg;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          freeze, flush;
    logic          id_valid;
    logic [DW-1:0] id_pc, id_val_rn, id_val_rm;
    logic [AW-1:0] id_src1, id_src2, id_dest;
    logic [3:0]    id_exe_cmd;
    logic          id_mem_r_en, id_mem_w_en, id_wb_en;
    logic          id_b, id_s, id_imm;
    logic [11:0]   id_shift_operand;
    logic [23:0]   id_signed_imm_24;
    logic          wb_en;
    logic [AW-1:0] wb_dest;
    logic [DW-1:0] wb_value;
    logic          ex_valid;
    logic [DW-1:0] ex_pc, ex_val_rn, ex_val_rm;
    logic [AW-1:0] ex_src1, ex_src2, ex_dest;
    logic [3:0]    ex_exe_cmd;
    logic          ex_mem_r_en, ex_mem_w_en, ex_wb_en;
    logic          ex_b, ex_s, ex_imm;
    logic [11:0]   ex_shift_operand;
    logic [23:0]   ex_signed_imm_24;
`ifdef ID_EX_STALL_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_val_rn(id_val_rn), .id_val_rm(id_val_rm),
        .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
        .id_exe_cmd(id_exe_cmd), .id_mem_r_en(id_mem_r_en),
        .id_mem_w_en(id_mem_w_en), .id_wb_en(id_wb_en),
        .id_b(id_b), .id_s(id_s), .id_imm(id_imm),
        .id_shift_operand(id_shift_operand),
        .id_signed_imm_24(id_signed_imm_24),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest),
        .ex_exe_cmd(ex_exe_cmd), .ex_mem_r_en(ex_mem_r_en),
        .ex_mem_w_en(ex_mem_w_en), .ex_wb_en(ex_wb_en),
        .ex_b(ex_b), .ex_s(ex_s), .ex_imm(ex_imm),
        .ex_shift_operand(ex_shift_operand),
`ifdef ID_EX_STALL_CNT_EN
        .ex_signed_imm_24(ex_signed_imm_24),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
        .ex_signed_imm_24(ex_signed_imm_24)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] pc,
                         input logic [DW-1:0] rn, input logic [DW-1:0] rm,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                         input logic [AW-1:0] d, input logic [3:0] cmd,
                         input logic [5:0] ctl, input logic [11:0] sh,
                         input logic [23:0] i24);
        id_valid = v; id_pc = pc; id_val_rn = rn; id_val_rm = rm;
        id_src1 = s1; id_src2 = s2; id_dest = d; id_exe_cmd = cmd;
        {id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s, id_imm} = ctl;
        id_shift_operand = sh; id_signed_imm_24 = i24;
    endtask

    task automatic wb(input logic e, input logic [AW-1:0] d,
                      input logic [DW-1:0] v);
        wb_en = e; wb_dest = d; wb_value = v;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        wb(1'b0, '0, '0);
        tick(); tick();
        chk("rst_valid", ex_valid, 0);
        chk("rst_pc", ex_pc, 0);
        rst = 1'b0;

        // Plain load, one-cycle latency
        drive(1'b1, 32'h104, 32'h5, 32'h11, 4'd3, 4'd4, 4'd7, 4'h9,
              6'b001010, 12'hABC, 24'h123456);
        tick();
        chk("ld_valid", ex_valid, 1);
        chk("ld_rn", ex_val_rn, 32'h5);
        chk("ld_dest", ex_dest, 7);
        chk("ld_wb_en", ex_wb_en, 1);
        chk("ld_s", ex_s, 1);
        chk("ld_pc", ex_pc, 32'h104);
        chk("ld_sh", ex_shift_operand, 12'hABC);
        chk("ld_i24", ex_signed_imm_24, 24'h123456);

        // No combinational id->ex path
        id_dest = 4'd9;
        #1 chk("no_comb", ex_dest, 7);

        // Freeze hold with changing inputs
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h900 + i, 32'hF0 + i, 32'hE0, 4'd1, 4'd2,
                  4'd8, 4'h2, 6'b110101, 12'h111, 24'h0);
            tick();
            chk("hold_rn", ex_val_rn, 32'h5);
            chk("hold_dest", ex_dest, 7);
            chk("hold_valid", ex_valid, 1);
        end
        chk("hold_pc", ex_pc, 32'h104);
        chk("hold_cmd", ex_exe_cmd, 4'h9);

        // Snoop both operands from register 3
        freeze = 1'b0;
        drive(1'b1, 32'h200, 32'h1, 32'h2, 4'd3, 4'd3, 4'd6, 4'h4,
              6'b010010, 12'h0, 24'h0);
        tick();
        freeze = 1'b1;
        wb(1'b1, 4'd3, 32'hDEADBEEF);
        tick();
        chk("snp_rn", ex_val_rn, 32'hDEADBEEF);
        chk("snp_rm", ex_val_rm, 32'hDEADBEEF);

        // PC index is never snooped
        wb(1'b1, 4'd15, 32'h12345678);
        tick();
        chk("snp_pc_rn", ex_val_rn, 32'hDEADBEEF);
        chk("snp_pc_rm", ex_val_rm, 32'hDEADBEEF);

        // wb_en low: no snoop
        wb(1'b0, 4'd3, 32'h77);
        tick();
        chk("snp_nowb", ex_val_rn, 32'hDEADBEEF);

        // Invalid slot is not snooped
        freeze = 1'b0; wb(1'b0, '0, '0);
        drive(1'b0, 32'h0, 32'hA, 32'hB, 4'd3, 4'd3, 4'd0, 4'h0,
              6'b000000, 12'h0, 24'h0);
        tick();
        chk("inv_valid", ex_valid, 0);
        freeze = 1'b1;
        wb(1'b1, 4'd3, 32'hCAFE);
        tick();
        chk("inv_rn", ex_val_rn, 32'hA);
        chk("inv_rm", ex_val_rm, 32'hB);

        // Only src2 matches
        freeze = 1'b0; wb(1'b0, '0, '0);
        drive(1'b1, 32'h300, 32'h10, 32'h20, 4'd3, 4'd5, 4'd1, 4'h1,
              6'b011000, 12'h0, 24'h0);
        tick();
        freeze = 1'b1;
        wb(1'b1, 4'd5, 32'h55);
        tick();
        chk("one_rn", ex_val_rn, 32'h10);
        chk("one_rm", ex_val_rm, 32'h55);
        chk("one_mw", ex_mem_w_en, 1);

        // Flush beats freeze
        wb(1'b0, '0, '0);
        flush = 1'b1;
        tick();
        chk("fl_valid", ex_valid, 0);
        chk("fl_wb_en", ex_wb_en, 0);
        chk("fl_mw", ex_mem_w_en, 0);
        chk("fl_pc", ex_pc, 0);
        chk("fl_rm", ex_val_rm, 0);
        flush = 1'b0; freeze = 1'b0;

        // Asynchronous reset mid-cycle
        drive(1'b1, 32'h400, 32'h9, 32'h8, 4'd2, 4'd1, 4'd4, 4'h3,
              6'b001000, 12'h5, 24'h6);
        tick();
        chk("pre_rst_valid", ex_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_rn", ex_val_rn, 0);
        chk("arst_dest", ex_dest, 0);
        tick();
        chk("rst_held", ex_pc, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ld", ex_pc, 32'h400);

`ifdef ID_EX_STALL_CNT_EN
        rst = 1'b1;
        #1;
        chk("cnt_rst", {stall_cnt, flush_cnt}, 0);
        rst = 1'b0;
        freeze = 1'b1;
        repeat (5) tick();
        freeze = 1'b0; flush = 1'b1;
        tick();
        freeze = 1'b1;
        tick();
        flush = 1'b0; freeze = 1'b0;
        chk("stall_cnt", stall_cnt, 5);
        chk("flush_cnt", flush_cnt, 2);
        freeze = 1'b1;
        repeat (4) tick();
        chk("stall_sat", stall_cnt, 7);
        freeze = 1'b0; flush = 1'b1;
        repeat (7) tick();
        chk("flush_sat", flush_cnt, 7);
        chk("stall_keep", stall_cnt, 7);
        flush = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register between the decode stage, which reads operands from the 15-entry register file, and the execute stage. Captures operand values, register addresses, and decoded control on each rising clock edge. Supports freeze (hazard stall) and flush (taken branch). While frozen it snoops write-back, so held operands stay coherent with the register file, which writes on the falling edge.

Parameters:
DATA_W, 32, operand/PC width
REG_ADDR_W, 4, register address width (index 15 = PC, never a file register)
CNT_W, 16, width of optional stall/flush counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
freeze  in  1  hold contents (hazard unit)
flush  in  1  kill contents (branch taken in EX)
id_valid  in  1  ID holds a real instruction
id_pc  in  DATA_W  PC+4 of ID instruction
id_val_rn  in  DATA_W  register file read port 1 data
id_val_rm  in  DATA_W  register file read port 2 data
id_src1  in  REG_ADDR_W  address used for read port 1
id_src2  in  REG_ADDR_W  address used for read port 2
id_dest  in  REG_ADDR_W  destination register
id_exe_cmd  in  4  ALU command
id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s, id_imm  in  1 each  decoded controls
id_shift_operand  in  12  shifter operand field
id_signed_imm_24  in  24  branch offset
wb_en  in  1  write-back enable (same signal driving the register file)
wb_dest  in  REG_ADDR_W  write-back destination
wb_value  in  DATA_W  write-back data
ex_*  out  (same widths)  registered copies of every id_* input above, prefixed ex_
ex_valid  out  1  EX holds a real instruction

Behaviour:
- Reset: rst is asynchronous and active-high. All ex_* outputs and ex_valid clear to 0 immediately and stay 0 while rst is high.
- Update on the rising clk edge. Priority is flush > freeze > load.
- flush=1:
  - ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s clear to 0.
  - All other ex_* fields also clear to 0, giving a deterministic bubble.
  - flush overrides a simultaneous freeze.
- freeze=1, flush=0: every ex_* field holds, with one snoop exception.
  - Snoop rule, evaluated each frozen rising edge: wb_en=1, ex_valid=1, and wb_dest==ex_src1 (wb_dest≠15) → ex_val_rn loads wb_value.
  - Same rule for ex_src2 / ex_val_rm. Both may update on the same edge.
  - The snoop ignores whether the instruction actually uses the operand; a harmless overwrite is acceptable.
- Load (freeze=0, flush=0):
  - Every ex_* field loads its id_* input; ex_valid <= id_valid.
  - No bypass is applied on load: the register file writes on the falling edge, so id_val_* already reflects a write-back from the same cycle.
- id_valid=0 on load: control enables load as presented. Decode guarantees they are 0 for an invalid slot; the block does not mask them.
- Latency: one cycle from ID inputs to ex_* outputs. No combinational path from id_* inputs to any output.
- Reset mid-freeze or mid-flush: reset wins; the first edge after rst falls performs a normal load or flush per the inputs.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- When defined, two extra outputs are added:
  - stall_cnt (CNT_W): counts rising edges with freeze=1, flush=0.
  - flush_cnt (CNT_W): counts rising edges with flush=1.
- Both counters saturate at all-ones and reset asynchronously to 0.
- When not defined, these ports and their registers do not exist and the module's function is unchanged.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1 → all outputs 0 immediately (before the next clock edge).
- Load: id_valid=1, id_val_rn=0x0000_0005, id_src1=3, id_dest=7, id_wb_en=1, edge → ex_val_rn=0x5, ex_dest=7, ex_wb_en=1, ex_valid=1 one cycle later.
- Freeze hold: freeze=1 for 3 edges with changing id_* inputs → ex_* unchanged across all 3 edges.
- Freeze snoop: held ex_src1=3, ex_src2=3; freeze=1, wb_en=1, wb_dest=3, wb_value=0xDEAD_BEEF → ex_val_rn=ex_val_rm=0xDEADBEEF next edge. Repeat with wb_dest=15 or ex_valid=0 → no change.
- Flush priority: flush=1 and freeze=1 with a valid instruction held → ex_valid=0, ex_wb_en=0, ex_mem_w_en=0, ex_pc=0 next edge.
- With ID_EX_STALL_CNT_EN: 5 freeze edges, 2 flush edges (one of them with freeze=1) → stall_cnt=5, flush_cnt=2. Preload to all-ones → the counter stays at all-ones.
